// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin burst arbiter for the shared LED register bus
//
// Purpose: shares one LED register bus between requester 0 (I2C controller
// path) and requester 1 (LED sequencer). Grants round-robin, holds the grant
// for a whole burst with address auto-increment (wrapping), and returns a
// per-beat ack, a done pulse on the final beat, and captured read data.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_sleep                 blocks new grants (a burst in progress completes)
//   i_reqN                  request, held until doneN
//   i_weN, i_addrN, i_lenN  burst direction, start address, beats-1 (sampled at grant)
//   i_wdataN                write data for the current beat
//   o_gntN                  requester N owns the bus (ACCESS and RESP of every beat)
//   o_ackN, o_doneN         per-beat ack pulse, done pulse with the final ack
//   o_rdataN                read data, valid with o_ackN
//   o_bus_addr              register address toward led_ctrl
//   o_bus_r_en, o_bus_w_en  read / write strobes
//   io_bus_data             driven with write data only during a write ACCESS cycle
module reg_bus_arbiter #(
  parameter int ADDR_BITS = 3,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_sleep,
  input  logic                 i_req0,
  input  logic                 i_req1,
  input  logic                 i_we0,
  input  logic                 i_we1,
  input  logic [ADDR_BITS-1:0] i_addr0,
  input  logic [ADDR_BITS-1:0] i_addr1,
  input  logic [2:0]           i_len0,
  input  logic [2:0]           i_len1,
  input  logic [DATA_BITS-1:0] i_wdata0,
  input  logic [DATA_BITS-1:0] i_wdata1,
  output logic                 o_gnt0,
  output logic                 o_gnt1,
  output logic                 o_ack0,
  output logic                 o_ack1,
  output logic                 o_done0,
  output logic                 o_done1,
  output logic [DATA_BITS-1:0] o_rdata0,
  output logic [DATA_BITS-1:0] o_rdata1,
  output logic [ADDR_BITS-1:0] o_bus_addr,
  output logic                 o_bus_r_en,
  output logic                 o_bus_w_en,
  inout  wire  [DATA_BITS-1:0] io_bus_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_win;    // index of the current owner
  logic                   r_we;
  logic                   r_fin;    // current beat is the last one of the burst
  logic                   r_last;   // last-granted requester, for tie breaking
  logic [ADDR_BITS-1:0]   r_start;
  logic [2:0]             r_len;
  logic [2:0]             r_beat;

  logic                   w_grant;
  logic                   w_pick;
  logic                   w_pick_we;
  logic [ADDR_BITS-1:0]   w_pick_addr;
  logic [2:0]             w_pick_len;
  logic                   w_req_win;
  logic                   w_last_beat;
  logic [2:0]             w_beat_inc;
  logic [DATA_BITS-1:0]   w_wdata;

  assign w_req_win   = r_win ? i_req1 : i_req0;
  assign w_wdata     = r_win ? i_wdata1 : i_wdata0;
  assign w_pick_we   = w_pick ? i_we1 : i_we0;
  assign w_pick_addr = w_pick ? i_addr1 : i_addr0;
  assign w_pick_len  = w_pick ? i_len1 : i_len0;
  assign w_beat_inc  = r_beat + 3'd1;
  // A dropped request ends the burst on the beat currently in ACCESS.
  assign w_last_beat = (r_beat == r_len) || !w_req_win;

  // Only the enable is combinational; the data follows the owner's wdata.
  assign io_bus_data = (r_state == ACCESS && r_we) ? w_wdata : {DATA_BITS{1'bz}};

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_pick      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_sleep && (i_req0 || i_req1)) begin
          w_grant     = 1'b1;
          // On a tie the requester that was not granted last wins.
          w_pick      = (i_req0 && i_req1) ? ~r_last : i_req1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = r_fin ? IDLE : ACCESS;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered on the edge entering the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_win      <= 1'b0;
      r_we       <= 1'b0;
      r_fin      <= 1'b0;
      r_last     <= 1'b1;
      r_start    <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      o_ack0     <= 1'b0;
      o_ack1     <= 1'b0;
      o_done0    <= 1'b0;
      o_done1    <= 1'b0;
      o_rdata0   <= '0;
      o_rdata1   <= '0;
      o_bus_addr <= '0;
      o_bus_r_en <= 1'b0;
      o_bus_w_en <= 1'b0;
    end else begin
      o_ack0  <= 1'b0;
      o_ack1  <= 1'b0;
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_win      <= w_pick;
            r_we       <= w_pick_we;
            r_start    <= w_pick_addr;
            r_len      <= w_pick_len;
            r_beat     <= 3'd0;
            r_fin      <= 1'b0;
            o_bus_addr <= w_pick_addr;
            o_bus_w_en <= w_pick_we;
            o_bus_r_en <= !w_pick_we;
            o_gnt0     <= !w_pick;
            o_gnt1     <= w_pick;
          end
        end
        ACCESS: begin
          o_bus_w_en <= 1'b0;
          o_bus_r_en <= 1'b0;
          r_fin      <= w_last_beat;
          if (r_win) begin
            o_ack1  <= 1'b1;
            o_done1 <= w_last_beat;
            if (!r_we) o_rdata1 <= io_bus_data;
          end else begin
            o_ack0  <= 1'b1;
            o_done0 <= w_last_beat;
            if (!r_we) o_rdata0 <= io_bus_data;
          end
        end
        RESP: begin
          if (r_fin) begin
            o_gnt0 <= 1'b0;
            o_gnt1 <= 1'b0;
            r_last <= r_win;
          end else begin
            r_beat     <= w_beat_inc;
            o_bus_addr <= r_start + ADDR_BITS'(w_beat_inc);
            o_bus_w_en <= r_we;
            o_bus_r_en <= !r_we;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - self-checking bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset, sleep, req0, req1, we0, we1;
  logic [2:0] addr0, addr1, len0, len1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, ack0, ack1, done0, done1;
  logic [7:0] rdata0, rdata1;
  logic [2:0] bus_addr;
  logic       bus_r_en, bus_w_en;
  wire  [7:0] bus_data;
  logic [7:0] salt;

  int n_checks = 0;
  int n_fail = 0;
  int exp_last;
  logic [7:0] exp_rdata [2];

  always #5 clk = ~clk;

  // led_ctrl stand-in: returns 0x10 + address + salt while read strobe is high
  assign bus_data = bus_r_en ? (8'h10 + {5'b0, bus_addr} + salt) : 8'hzz;

  reg_bus_arbiter #(.ADDR_BITS(3), .DATA_BITS(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_sleep(sleep),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_len0(len0), .i_len1(len1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_ack0(ack0), .o_ack1(ack1),
    .o_done0(done0), .o_done1(done1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_bus_addr(bus_addr), .o_bus_r_en(bus_r_en), .o_bus_w_en(bus_w_en),
    .io_bus_data(bus_data)
  );

  // Reference arbitration rule: tie goes to the requester not granted last.
  function automatic int pick_winner(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 1) ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; sleep = 1'b0; req0 = 1'b0; req1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = 3'd0; addr1 = 3'd0;
    len0 = 3'd0; len1 = 3'd0; wdata0 = 8'h3C; wdata1 = 8'hC3; salt = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, ack0, ack1, done0, done1, bus_w_en, bus_r_en} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000", {gnt0, gnt1, ack0, ack1, done0, done1, bus_w_en, bus_r_en});
    end
    n_checks++;
    if ({bus_addr, rdata0, rdata1} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%0d rdata0=%h rdata1=%h want 0/00/00", bus_addr, rdata0, rdata1);
    end
    n_checks++;
    if (!$isunknown(bus_data) && bus_data === wdata0) begin
      n_fail++;
      $display("FAIL reset_bus_released: bus_data=%h carries wdata %h", bus_data, wdata0);
    end
    reset = 1'b0;
    exp_last = 1;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
  endtask

  task automatic test_single_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd2; len0 = 3'd0; wdata0 = 8'h5A;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, bus_w_en, bus_r_en, bus_addr, bus_data} !== {4'b1010, 3'd2, 8'h5A}) begin
      n_fail++;
      $display("FAIL single_access: got gnt0=%b gnt1=%b w=%b r=%b addr=%0d data=%h want 1 0 1 0 2 5a",
               gnt0, gnt1, bus_w_en, bus_r_en, bus_addr, bus_data);
    end
    @(negedge clk);
    n_checks++;
    if ({ack0, done0, ack1, done1, gnt0, gnt1, bus_w_en} !== 7'b1100100) begin
      n_fail++;
      $display("FAIL single_resp: got %b want 1100100", {ack0, done0, ack1, done1, gnt0, gnt1, bus_w_en});
    end
    n_checks++;
    if (!$isunknown(bus_data) && bus_data === wdata0) begin
      n_fail++;
      $display("FAIL single_resp_released: bus_data=%h still carries wdata", bus_data);
    end
    req0 = 1'b0;
    exp_last = 0;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle_gnt: got %b want 00", {gnt0, gnt1});
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0] ev;
    int a;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd6; len1 = 3'd3; salt = 8'h00;
    for (int b = 0; b < 4; b++) begin
      a = (6 + b) % 8;
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0, bus_r_en, bus_w_en, bus_addr} !== {4'b1010, 3'(a)}) begin
        n_fail++;
        $display("FAIL read_access beat %0d: got gnt1=%b gnt0=%b r=%b w=%b addr=%0d want 1 0 1 0 %0d",
                 b, gnt1, gnt0, bus_r_en, bus_w_en, bus_addr, a);
      end
      @(negedge clk);
      ev = 8'h10 + 8'(a);
      n_checks++;
      if ({ack1, done1, rdata1} !== {1'b1, (b == 3), ev}) begin
        n_fail++;
        $display("FAIL read_resp beat %0d: got ack1=%b done1=%b rdata1=%h want 1 %0d %h",
                 b, ack1, done1, rdata1, (b == 3), ev);
      end
      if (b == 3) req1 = 1'b0;
    end
    exp_last = 1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int w;
    logic [3:0] order;
    order = 4'b0000;
    for (int round = 0; round < 2; round++) begin
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; len0 = 3'd0; len1 = 3'd0;
      addr0 = 3'($urandom); addr1 = 3'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      for (int k = 0; k < 2; k++) begin
        w = pick_winner(req0, req1, exp_last);
        @(negedge clk);
        order[round * 2 + k] = gnt1;
        n_checks++;
        if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL rr_grant r%0d k%0d: got gnt1=%b gnt0=%b want winner %0d", round, k, gnt1, gnt0, w);
        end
        @(negedge clk);
        n_checks++;
        if ((w == 1 ? done1 : done0) !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_done r%0d k%0d: got done0=%b done1=%b want winner %0d", round, k, done0, done1, w);
        end
        if (w == 1) req1 = 1'b0; else req0 = 1'b0;
        exp_last = w;
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, bus_w_en, bus_r_en} !== 4'b0000) begin
          n_fail++;
          $display("FAIL rr_gap r%0d k%0d: got gnt0=%b gnt1=%b w=%b r=%b in cycle after done want 0000",
                   round, k, gnt0, gnt1, bus_w_en, bus_r_en);
        end
      end
    end
    n_checks++;
    if (order !== 4'b1010) begin
      n_fail++;
      $display("FAIL rr_order: got gnt1 sequence %b want 1010 (order 0,1,0,1)", order);
    end
  endtask

  task automatic test_sleep();
    int w;
    logic [7:0] ev;
    salt = 8'($urandom);
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'($urandom); len0 = 3'd4; wdata0 = 8'($urandom);
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'($urandom); len1 = 3'd0;
    w = pick_winner(req0, req1, exp_last);
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, bus_w_en, bus_addr, bus_data} !== {(w == 0), (w == 1), 1'b1, 3'(addr0 + 3'(b)), wdata0}) begin
        n_fail++;
        $display("FAIL sleep_access beat %0d: got gnt0=%b gnt1=%b w=%b addr=%0d data=%h want %0d %0d 1 %0d %h",
                 b, gnt0, gnt1, bus_w_en, bus_addr, bus_data, (w == 0), (w == 1), 3'(addr0 + 3'(b)), wdata0);
      end
      if (b == 2) sleep = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({ack0, done0} !== {1'b1, (b == 4)}) begin
        n_fail++;
        $display("FAIL sleep_resp beat %0d: got ack0=%b done0=%b want 1 %0d", b, ack0, done0, (b == 4));
      end
      wdata0 = 8'($urandom);
      if (b == 4) req0 = 1'b0;
    end
    exp_last = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, bus_r_en, bus_w_en} !== 4'b0000) begin
        n_fail++;
        $display("FAIL sleep_block c%0d: got gnt0=%b gnt1=%b r=%b w=%b want 0000", c, gnt0, gnt1, bus_r_en, bus_w_en);
      end
    end
    sleep = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt1, gnt0, bus_r_en, bus_addr} !== {3'b101, addr1}) begin
      n_fail++;
      $display("FAIL sleep_wake: got gnt1=%b gnt0=%b r=%b addr=%0d want 1 0 1 %0d", gnt1, gnt0, bus_r_en, bus_addr, addr1);
    end
    @(negedge clk);
    ev = 8'h10 + {5'b0, addr1} + salt;
    n_checks++;
    if ({ack1, done1, rdata1} !== {2'b11, ev}) begin
      n_fail++;
      $display("FAIL sleep_read: got ack1=%b done1=%b rdata1=%h want 1 1 %h", ack1, done1, rdata1, ev);
    end
    req1 = 1'b0;
    exp_last = 1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int w;
    for (int keep0 = 0; keep0 < 2; keep0++) begin
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'($urandom); len0 = 3'd3; wdata0 = 8'($urandom) | 8'h01;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({gnt0, bus_w_en} !== 2'b11) begin
        n_fail++;
        $display("FAIL rst_mid_beat2 k%0d: got gnt0=%b w=%b want 1 1", keep0, gnt0, bus_w_en);
      end
      req1 = 1'b1; we1 = 1'b1; len1 = 3'd0;
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus_w_en, bus_r_en, gnt0, gnt1, ack0, done0, bus_addr} !== 9'd0) begin
        n_fail++;
        $display("FAIL rst_mid_clear k%0d: got w=%b r=%b gnt0=%b gnt1=%b ack0=%b done0=%b addr=%0d want all 0",
                 keep0, bus_w_en, bus_r_en, gnt0, gnt1, ack0, done0, bus_addr);
      end
      n_checks++;
      if (!$isunknown(bus_data) && bus_data === wdata0) begin
        n_fail++;
        $display("FAIL rst_mid_released k%0d: bus_data=%h still carries wdata", keep0, bus_data);
      end
      reset = 1'b0;
      req0 = 1'(keep0);
      exp_last = 1;
      w = pick_winner(req0, req1, exp_last);
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rst_mid_regrant k%0d: got gnt1=%b gnt0=%b want winner %0d", keep0, gnt1, gnt0, w);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if ((w == 1 ? {ack1, done1} : {ack0, done0}) !== 2'b11) begin
        n_fail++;
        $display("FAIL rst_mid_drop_done k%0d: got ack/done=%b%b (0) %b%b (1) want winner %0d 11",
                 keep0, ack0, done0, ack1, done1, w);
      end
      exp_last = w;
      @(negedge clk);
    end
  endtask

  task automatic test_req_drop();
    int w_cnt, ack_cnt, done_cnt, done_at;
    w_cnt = 0; ack_cnt = 0; done_cnt = 0; done_at = -1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'($urandom); len0 = 3'd4; wdata0 = 8'($urandom);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus_w_en === 1'b1) w_cnt++;
      if (ack0 === 1'b1) begin
        ack_cnt++;
        if (done0 === 1'b1) done_at = ack_cnt;
      end
      if (done0 === 1'b1) done_cnt++;
      if (cyc == 1) req0 = 1'b0;
    end
    exp_last = 0;
    n_checks++;
    if (w_cnt != 2) begin
      n_fail++;
      $display("FAIL drop_strobes: got %0d w_en strobes want 2", w_cnt);
    end
    n_checks++;
    if (ack_cnt != 2 || done_cnt != 1 || done_at != 2) begin
      n_fail++;
      $display("FAIL drop_done: got acks=%0d dones=%0d done_on_ack=%0d want 2 1 2", ack_cnt, done_cnt, done_at);
    end
    n_checks++;
    if ({gnt0, gnt1, bus_w_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL drop_idle: got gnt0=%b gnt1=%b w=%b want 000", gnt0, gnt1, bus_w_en);
    end
  endtask

  task automatic test_random();
    int w, a;
    int p;
    logic wwe;
    logic [2:0] wa, wl;
    logic [7:0] wd;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_last = 1;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    for (int n = 0; n < 24; n++) begin
      p = $urandom_range(1, 3);
      req0 = p[0]; req1 = p[1];
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = 3'($urandom); addr1 = 3'($urandom);
      len0 = 3'($urandom); len1 = 3'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      salt = 8'($urandom);
      w = pick_winner(req0, req1, exp_last);
      wwe = (w == 1) ? we1 : we0;
      wa = (w == 1) ? addr1 : addr0;
      wl = (w == 1) ? len1 : len0;
      for (int b = 0; b <= int'(wl); b++) begin
        a = (int'(wa) + b) % 8;
        wd = (w == 1) ? wdata1 : wdata0;
        @(negedge clk);
        n_checks++;
        if ({gnt1, gnt0, bus_w_en, bus_r_en, bus_addr} !== {(w == 1), (w == 0), wwe, !wwe, 3'(a)}) begin
          n_fail++;
          $display("FAIL rnd_access n%0d b%0d: got gnt1=%b gnt0=%b w=%b r=%b addr=%0d want %0d %0d %b %b %0d",
                   n, b, gnt1, gnt0, bus_w_en, bus_r_en, bus_addr, (w == 1), (w == 0), wwe, !wwe, a);
        end
        if (wwe) begin
          n_checks++;
          if (bus_data !== wd) begin
            n_fail++;
            $display("FAIL rnd_wdata n%0d b%0d: got %h want %h", n, b, bus_data, wd);
          end
        end
        @(negedge clk);
        if (!wwe) exp_rdata[w] = 8'h10 + 8'(a) + salt;
        n_checks++;
        if ((w == 1 ? {ack1, done1, ack0, rdata1} : {ack0, done0, ack1, rdata0}) !==
            {1'b1, (b == int'(wl)), 1'b0, exp_rdata[w]}) begin
          n_fail++;
          $display("FAIL rnd_resp n%0d b%0d: got ack0=%b done0=%b ack1=%b done1=%b rdata0=%h rdata1=%h want winner %0d done %0d rdata %h",
                   n, b, ack0, done0, ack1, done1, rdata0, rdata1, w, (b == int'(wl)), exp_rdata[w]);
        end
        if (w == 1) wdata1 = 8'($urandom); else wdata0 = 8'($urandom);
        if (b == int'(wl)) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
      exp_last = w;
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1} !== 2'b00) begin
        n_fail++;
        $display("FAIL rnd_idle n%0d: got gnt0=%b gnt1=%b want 00", n, gnt0, gnt1);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_read_wrap();
    test_round_robin();
    test_sleep();
    test_reset_mid_burst();
    test_req_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
